// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : video_timing_gen
//  Brief    : Raster timing generator. Produces pixel coordinates for a pixel
//             source, then re-aligns sync/data-enable with the returned pixel
//             through a delay line matching the source latency.
//  Revision : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
  parameter int   FRAME_WIDTH   = 2200,
  parameter int   FRAME_HEIGHT  = 1125,
  parameter int   SCREEN_WIDTH  = 1920,
  parameter int   SCREEN_HEIGHT = 1080,
  parameter int   H_FRONT       = 88,
  parameter int   H_SYNC        = 44,
  parameter int   V_FRONT       = 4,
  parameter int   V_SYNC        = 5,
  parameter logic SYNC_POL      = 1'b1,
  parameter int   RGB_LATENCY   = 2,
  parameter int   BIT_WIDTH     = 12,
  parameter int   BIT_HEIGHT    = 11
) (
  input  logic                  pixel_clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic [BIT_WIDTH-1:0]  cx,
  output logic [BIT_HEIGHT-1:0] cy,
  input  logic [23:0]           rgb_in,
  output logic [23:0]           rgb_out,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic                  de_out,
  output logic                  frame_start,
  output logic                  line_start
);

  // Raster boundaries at full counter width so every compare is unsigned.
  localparam logic [BIT_WIDTH-1:0]  c_h_last   = BIT_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [BIT_WIDTH-1:0]  c_h_active = BIT_WIDTH'(SCREEN_WIDTH);
  localparam logic [BIT_WIDTH-1:0]  c_hs_start = BIT_WIDTH'(SCREEN_WIDTH + H_FRONT);
  localparam logic [BIT_WIDTH-1:0]  c_hs_end   = BIT_WIDTH'(SCREEN_WIDTH + H_FRONT + H_SYNC);
  localparam logic [BIT_HEIGHT-1:0] c_v_last   = BIT_HEIGHT'(FRAME_HEIGHT - 1);
  localparam logic [BIT_HEIGHT-1:0] c_v_active = BIT_HEIGHT'(SCREEN_HEIGHT);
  localparam logic [BIT_HEIGHT-1:0] c_vs_start = BIT_HEIGHT'(SCREEN_HEIGHT + V_FRONT);
  localparam logic [BIT_HEIGHT-1:0] c_vs_end   = BIT_HEIGHT'(SCREEN_HEIGHT + V_FRONT + V_SYNC);

  logic [BIT_WIDTH-1:0]   cx_q, cx_d;
  logic [BIT_HEIGHT-1:0]  cy_q, cy_d;
  logic                   de_raw, hs_raw, vs_raw;
  logic [RGB_LATENCY-1:0] de_dly_q, hs_dly_q, vs_dly_q;
  logic                   de_out_q, hs_out_q, vs_out_q;
  logic [23:0]            rgb_out_q;

  // Counter next state: hold at origin while disabled; >= keeps a wrap even
  // if a counter were ever out of range.
  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (!enable) begin
      cx_d = '0;
      cy_d = '0;
    end else if (cx_q >= c_h_last) begin
      cx_d = '0;
      cy_d = (cy_q >= c_v_last) ? '0 : cy_q + BIT_HEIGHT'(1);
    end else begin
      cx_d = cx_q + BIT_WIDTH'(1);
    end
  end

  // Position counter registers.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  // Undelayed timing decoded from the current position; vsync depends only on
  // cy, so it can only change when cx wraps to 0.
  always_comb begin
    de_raw = enable && (cx_q < c_h_active) && (cy_q < c_v_active);
    hs_raw = ((cx_q >= c_hs_start) && (cx_q < c_hs_end)) ? SYNC_POL : ~SYNC_POL;
    vs_raw = ((cy_q >= c_vs_start) && (cy_q < c_vs_end)) ? SYNC_POL : ~SYNC_POL;
  end

  // Delay line matching the pixel source latency; keeps shifting while
  // disabled so in-flight pixels drain out.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      de_dly_q <= '0;
      hs_dly_q <= {RGB_LATENCY{~SYNC_POL}};
      vs_dly_q <= {RGB_LATENCY{~SYNC_POL}};
    end else begin
      de_dly_q[0] <= de_raw;
      hs_dly_q[0] <= hs_raw;
      vs_dly_q[0] <= vs_raw;
      for (int i = 1; i < RGB_LATENCY; i++) begin
        de_dly_q[i] <= de_dly_q[i-1];
        hs_dly_q[i] <= hs_dly_q[i-1];
        vs_dly_q[i] <= vs_dly_q[i-1];
      end
    end
  end

  // Output register: pixel captured in the same cycle its delayed de arrives.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      de_out_q  <= 1'b0;
      hs_out_q  <= ~SYNC_POL;
      vs_out_q  <= ~SYNC_POL;
      rgb_out_q <= 24'h000000;
    end else begin
      de_out_q  <= de_dly_q[RGB_LATENCY-1];
      hs_out_q  <= hs_dly_q[RGB_LATENCY-1];
      vs_out_q  <= vs_dly_q[RGB_LATENCY-1];
      rgb_out_q <= de_dly_q[RGB_LATENCY-1] ? rgb_in : 24'h000000;
    end
  end

  // Start pulses follow the live enable so a restart flags the origin cycle.
  always_comb begin
    frame_start = enable && !reset && (cx_q == '0) && (cy_q == '0);
    line_start  = enable && !reset && (cx_q == '0);
  end

  assign cx        = cx_q;
  assign cy        = cy_q;
  assign de_out    = de_out_q;
  assign hsync_out = hs_out_q;
  assign vsync_out = vs_out_q;
  assign rgb_out   = rgb_out_q;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_video_timing_gen
//  Brief    : Directed self-checking bench for video_timing_gen on a small
//             10x6 raster with a 2-cycle pixel source.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [11:0] cx;
  logic [10:0] cy;
  logic [23:0] rgb_in;
  logic [23:0] rgb_out;
  logic        hsync_out, vsync_out, de_out, frame_start, line_start;

  int checks = 0;
  int errors = 0;

  video_timing_gen #(
    .FRAME_WIDTH(10), .FRAME_HEIGHT(6), .SCREEN_WIDTH(6), .SCREEN_HEIGHT(4),
    .H_FRONT(1), .H_SYNC(2), .V_FRONT(1), .V_SYNC(1),
    .SYNC_POL(1'b1), .RGB_LATENCY(2), .BIT_WIDTH(12), .BIT_HEIGHT(11)
  ) dut (
    .pixel_clk(clk), .reset(rst), .enable(en),
    .cx(cx), .cy(cy), .rgb_in(rgb_in), .rgb_out(rgb_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out),
    .frame_start(frame_start), .line_start(line_start)
  );

  always #5 clk = ~clk;

  // Pixel source: returns {cy,cx} two cycles after the coordinates.
  logic [23:0] p1_q, p2_q;
  always @(posedge clk) begin
    p1_q <= {1'b0, cy, cx};
    p2_q <= p1_q;
  end
  assign rgb_in = p2_q;

  // Reference raster state (value visible in the current cycle).
  int          mcx, mcy;
  logic        sde [2];
  logic        shs [2];
  logic        svs [2];
  logic [23:0] spix [2];
  logic        ode, ohs, ovs;
  logic [23:0] orgb;
  logic        s_de, s_hs, s_vs, s_fs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cx=%0d cy=%0d)", tag, obs, exp, mcx, mcy);
    end
  endtask

  // Advance the reference by one rising edge with the given inputs.
  task automatic model_step(input logic r, input logic e);
    if (r) begin
      mcx = 0; mcy = 0;
      for (int k = 0; k < 2; k++) begin
        sde[k] = 1'b0; shs[k] = 1'b0; svs[k] = 1'b0; spix[k] = 24'h0;
      end
      ode = 1'b0; ohs = 1'b0; ovs = 1'b0; orgb = 24'h0;
    end else begin
      ode  = sde[1]; ohs = shs[1]; ovs = svs[1];
      orgb = sde[1] ? spix[1] : 24'h0;
      sde[1] = sde[0]; shs[1] = shs[0]; svs[1] = svs[0]; spix[1] = spix[0];
      sde[0]  = e && (mcx < 6) && (mcy < 4);
      shs[0]  = (mcx >= 7) && (mcx <= 8);
      svs[0]  = (mcy == 5);
      spix[0] = {1'b0, 11'(mcy), 12'(mcx)};
      if (!e) begin
        mcx = 0; mcy = 0;
      end else if (mcx == 9) begin
        mcx = 0;
        mcy = (mcy == 5) ? 0 : mcy + 1;
      end else begin
        mcx = mcx + 1;
      end
    end
  endtask

  // One cycle: apply inputs, check every output mid-low-phase, then advance.
  task automatic tick(input logic r, input logic e);
    rst = r;
    en  = e;
    #1;
    s_de = de_out; s_hs = hsync_out; s_vs = vsync_out; s_fs = frame_start;
    chk("cx",          32'(cx),          32'(mcx));
    chk("cy",          32'(cy),          32'(mcy));
    chk("frame_start", 32'(frame_start), 32'(e && !r && mcx == 0 && mcy == 0));
    chk("line_start",  32'(line_start),  32'(e && !r && mcx == 0));
    chk("de_out",      32'(de_out),      32'(ode));
    chk("hsync_out",   32'(hsync_out),   32'(ohs));
    chk("vsync_out",   32'(vsync_out),   32'(ovs));
    chk("rgb_out",     32'(rgb_out),     32'(orgb));
    @(posedge clk);
    model_step(r, e);
    @(negedge clk);
  endtask

  // Directed sequence: reset, raster, enable drop, mid-frame reset.
  initial begin
    int n_de, n_hs, n_vs, n_fs, guard;
    rst = 1'b1;
    en  = 1'b0;
    @(posedge clk);
    model_step(1'b1, 1'b0);
    @(negedge clk);

    // Reset wins over enable: no start pulse while held.
    tick(1'b1, 1'b1);

    // Raster: one full 60-cycle frame plus pipeline fill.
    n_de = 0; n_hs = 0; n_vs = 0; n_fs = 0;
    for (int i = 0; i < 63; i++) begin
      tick(1'b0, 1'b1);
      if (i == 0 || i == 60) chk("frame_start_at_0_60", 32'(s_fs), 32'd1);
      if (s_fs) n_fs++;
      if (i >= 3) begin
        if (s_de) n_de++;
        if (s_hs) n_hs++;
        if (s_vs) n_vs++;
      end
    end
    chk("de_cycles_per_frame",    32'(n_de), 32'd24);
    chk("hsync_cycles_per_frame", 32'(n_hs), 32'd12);
    chk("vsync_cycles_per_frame", 32'(n_vs), 32'd10);
    chk("frame_start_count",      32'(n_fs), 32'd2);

    // Enable drop at (3,1).
    guard = 0;
    while (!(mcx == 3 && mcy == 1) && guard < 100) begin
      tick(1'b0, 1'b1);
      guard++;
    end
    chk("reach_3_1_in_budget", 32'(guard < 100), 32'd1);
    for (int d = 0; d < 5; d++) begin
      tick(1'b0, 1'b0);
      if (d >= 3) chk("de_low_after_drop", 32'(s_de), 32'd0);
    end
    tick(1'b0, 1'b1);
    chk("frame_start_on_reassert", 32'(s_fs), 32'd1);

    // Reset mid-frame at (5,2).
    guard = 0;
    while (!(mcx == 5 && mcy == 2) && guard < 100) begin
      tick(1'b0, 1'b1);
      guard++;
    end
    chk("reach_5_2_in_budget", 32'(guard < 100), 32'd1);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    chk("reset_de_out", 32'(s_de), 32'd0);
    tick(1'b0, 1'b1);
    chk("frame_start_after_reset", 32'(s_fs), 32'd1);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
